// File: rtl/wb_regfile_if.sv
// Writeback/Decode-side bus of the architectural register file.
// The master drives the write port and read addresses; the register file is the slave.
interface wb_regfile_if #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
);
    logic               RegWriteW;
    logic [A_WIDTH-1:0] RdW;
    logic [D_WIDTH-1:0] ResultW;
    logic [A_WIDTH-1:0] A1;
    logic [A_WIDTH-1:0] A2;
    logic [D_WIDTH-1:0] RD1;
    logic [D_WIDTH-1:0] RD2;
    logic [D_WIDTH-1:0] a0;
    logic               ready;

    modport master (
        output RegWriteW, RdW, ResultW, A1, A2,
        input  RD1, RD2, a0, ready
    );

    modport slave (
        input  RegWriteW, RdW, ResultW, A1, A2,
        output RD1, RD2, a0, ready
    );
endinterface

// File: rtl/wb_regfile.sv
// RV32I architectural register file with a post-reset clear sweep and two async read ports.
// Define WB_REGFILE_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module wb_regfile #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);
    localparam int DEPTH = 2 ** A_WIDTH;
    localparam logic [A_WIDTH-1:0] A0_IDX = A_WIDTH'(10);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t             state;
    logic [A_WIDTH-1:0] idx;
    logic [D_WIDTH-1:0] regs [DEPTH];
    logic               wr_en;

    assign wr_en = bus.RegWriteW && (bus.RdW != '0);

    // Storage is never reset; the CLEAR state sweeps it to zero one entry per edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    regs[idx] <= '0;
                    idx       <= idx + 1'b1;
                    if (idx == '1) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (wr_en) begin
                        regs[bus.RdW] <= bus.ResultW;
                    end
                end
                default: begin
                    state <= CLEAR;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign bus.ready = (state == RUN);

    always_comb begin
        bus.RD1 = '0;
        bus.RD2 = '0;
        bus.a0  = '0;
        if (state == RUN) begin
            bus.a0 = regs[A0_IDX];
            if (bus.A1 != '0) begin
                bus.RD1 = regs[bus.A1];
            end
            if (bus.A2 != '0) begin
                bus.RD2 = regs[bus.A2];
            end
`ifdef WB_REGFILE_BYPASS_EN
            if (wr_en && (bus.RdW == bus.A1)) begin
                bus.RD1 = bus.ResultW;
            end
            if (wr_en && (bus.RdW == bus.A2)) begin
                bus.RD2 = bus.ResultW;
            end
`else
`endif
        end
    end
endmodule
